csr_file: RTL and testbench

Machine/supervisor CSR register file for the RV32 core. It is the responder end of the trap controller's CSR write interface. It holds every implemented CSR and drives their current values back to the trap controller. It also services the write-back stage's Zicsr writes and the decode stage's CSR reads. It sits beside the trap controller in the WB/commit region and owns the current privilege level and the cycle/instret counters.

---
 rtl/csr_file.sv | 210 +++++++++++++++++++++
 tb/tb_csr_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : RV32 machine/supervisor CSR storage, counters and privilege,
//               written by the trap controller and the WB-stage Zicsr path.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4014_1101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_wen_i,
    input  logic [11:0] trap_waddr_i,
    input  logic [31:0] trap_wdata_i,
    input  logic        inst_wen_i,
    input  logic [11:0] inst_waddr_i,
    input  logic [31:0] inst_wdata_i,
    input  logic [11:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        rillegal_o,
    input  logic        instret_i,
    input  logic        privilege_valid_i,
    input  logic [1:0]  privilege_i,
    output logic [1:0]  privilege_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic [31:0] csr_mtval_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_medeleg_o,
    output logic [31:0] csr_mideleg_o,
    output logic [31:0] csr_stvec_o,
    output logic [31:0] csr_sepc_o,
    output logic [31:0] csr_scause_o,
    output logic [31:0] csr_stval_o,
    output logic [31:0] csr_sstatus_o,
    output logic [31:0] csr_sie_o,
    output logic [31:0] csr_sip_o,
    output logic [31:0] csr_satp_o
);

    localparam logic [31:0] C_SSTATUS_MASK = 32'h000C_0122;
    localparam logic [31:0] C_SI_MASK      = 32'h0000_0222;

    localparam logic [11:0] C_SSTATUS  = 12'h100, C_SIE      = 12'h104, C_STVEC    = 12'h105;
    localparam logic [11:0] C_SSCRATCH = 12'h140, C_SEPC     = 12'h141, C_SCAUSE   = 12'h142;
    localparam logic [11:0] C_STVAL    = 12'h143, C_SIP      = 12'h144, C_SATP     = 12'h180;
    localparam logic [11:0] C_MSTATUS  = 12'h300, C_MISA     = 12'h301, C_MEDELEG  = 12'h302;
    localparam logic [11:0] C_MIDELEG  = 12'h303, C_MIE      = 12'h304, C_MTVEC    = 12'h305;
    localparam logic [11:0] C_MSCRATCH = 12'h340, C_MEPC     = 12'h341, C_MCAUSE   = 12'h342;
    localparam logic [11:0] C_MTVAL    = 12'h343, C_MIP      = 12'h344;
    localparam logic [11:0] C_MCYCLE   = 12'hB00, C_MINSTRET = 12'hB02;
    localparam logic [11:0] C_MCYCLEH  = 12'hB80, C_MINSTRETH = 12'hB82;
    localparam logic [11:0] C_CYCLE    = 12'hC00, C_INSTRET  = 12'hC02;
    localparam logic [11:0] C_CYCLEH   = 12'hC80, C_INSTRETH = 12'hC82, C_MHARTID = 12'hF14;

    logic [31:0] r_mstatus, r_mtvec, r_mepc, r_mcause, r_mtval, r_mie, r_mip;
    logic [31:0] r_medeleg, r_mideleg, r_mscratch;
    logic [31:0] r_stvec, r_sepc, r_scause, r_stval, r_sscratch, r_satp;
    logic [63:0] r_mcycle, r_minstret;
    logic [1:0]  r_priv;

    logic        w_wen;
    logic [11:0] w_waddr;
    logic [31:0] w_wdata;
    logic [31:0] w_wval;
    logic        w_writable;
    logic        w_commit;
    logic [63:0] w_cyc_next, w_ret_next;

    function automatic logic [31:0] f_mstatus_warl(input logic [31:0] d);
        logic [31:0] v;
        v = d;
        if (d[12:11] == 2'b10) v[12:11] = 2'b00;
        return v;
    endfunction

    // The trap port wins; a concurrent Zicsr write belongs to a flushed instruction.
    assign w_wen   = trap_wen_i | inst_wen_i;
    assign w_waddr = trap_wen_i ? trap_waddr_i : inst_waddr_i;
    assign w_wdata = trap_wen_i ? trap_wdata_i : inst_wdata_i;

    // w_wval is what the addressed CSR reads back after the write; views carry only their bits.
    always_comb begin
        w_writable = 1'b1;
        w_wval     = w_wdata;
        case (w_waddr)
            C_MSTATUS:        w_wval = f_mstatus_warl(w_wdata);
            C_SSTATUS:        w_wval = w_wdata & C_SSTATUS_MASK;
            C_SIE, C_SIP:     w_wval = w_wdata & C_SI_MASK;
            C_MEPC, C_SEPC:   w_wval = {w_wdata[31:1], 1'b0};
            C_MTVEC, C_STVEC: w_wval = {w_wdata[31:2], 1'b0, w_wdata[0]};
            C_MCAUSE, C_MTVAL, C_MIE, C_MIP, C_MEDELEG, C_MIDELEG, C_MSCRATCH,
            C_SCAUSE, C_STVAL, C_SSCRATCH, C_SATP,
            C_MCYCLE, C_MCYCLEH, C_MINSTRET, C_MINSTRETH: w_wval = w_wdata;
            default:          w_writable = 1'b0;
        endcase
    end

    assign w_commit = w_wen & w_writable;

    // A written counter half takes the write value instead of its increment.
    always_comb begin
        w_cyc_next = r_mcycle + 64'd1;
        w_ret_next = r_minstret + {63'd0, instret_i};
        if (w_commit && w_waddr == C_MCYCLE)    w_cyc_next[31:0]  = w_wval;
        if (w_commit && w_waddr == C_MCYCLEH)   w_cyc_next[63:32] = w_wval;
        if (w_commit && w_waddr == C_MINSTRET)  w_ret_next[31:0]  = w_wval;
        if (w_commit && w_waddr == C_MINSTRETH) w_ret_next[63:32] = w_wval;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus  <= 32'h0000_1800;
            r_mtvec    <= '0; r_mepc    <= '0; r_mcause   <= '0; r_mtval  <= '0;
            r_mie      <= '0; r_mip     <= '0; r_medeleg  <= '0; r_mideleg <= '0;
            r_mscratch <= '0; r_stvec   <= '0; r_sepc     <= '0; r_scause <= '0;
            r_stval    <= '0; r_sscratch <= '0; r_satp    <= '0;
            r_mcycle   <= '0; r_minstret <= '0;
            r_priv     <= 2'b11;
        end else begin
            r_mcycle   <= w_cyc_next;
            r_minstret <= w_ret_next;
            if (privilege_valid_i) r_priv <= privilege_i;
            if (w_commit) begin
                case (w_waddr)
                    C_MSTATUS:  r_mstatus  <= w_wval;
                    C_SSTATUS:  r_mstatus  <= (r_mstatus & ~C_SSTATUS_MASK) | w_wval;
                    C_MIE:      r_mie      <= w_wval;
                    C_SIE:      r_mie      <= (r_mie & ~C_SI_MASK) | w_wval;
                    C_MIP:      r_mip      <= w_wval;
                    C_SIP:      r_mip      <= (r_mip & ~C_SI_MASK) | w_wval;
                    C_MTVEC:    r_mtvec    <= w_wval;
                    C_MEPC:     r_mepc     <= w_wval;
                    C_MCAUSE:   r_mcause   <= w_wval;
                    C_MTVAL:    r_mtval    <= w_wval;
                    C_MEDELEG:  r_medeleg  <= w_wval;
                    C_MIDELEG:  r_mideleg  <= w_wval;
                    C_MSCRATCH: r_mscratch <= w_wval;
                    C_STVEC:    r_stvec    <= w_wval;
                    C_SEPC:     r_sepc     <= w_wval;
                    C_SCAUSE:   r_scause   <= w_wval;
                    C_STVAL:    r_stval    <= w_wval;
                    C_SSCRATCH: r_sscratch <= w_wval;
                    C_SATP:     r_satp     <= w_wval;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rillegal_o = 1'b0;
        rdata_o    = '0;
        case (raddr_i)
            C_SSTATUS:                rdata_o = r_mstatus & C_SSTATUS_MASK;
            C_SIE:                    rdata_o = r_mie & C_SI_MASK;
            C_SIP:                    rdata_o = r_mip & C_SI_MASK;
            C_STVEC:                  rdata_o = r_stvec;
            C_SSCRATCH:               rdata_o = r_sscratch;
            C_SEPC:                   rdata_o = r_sepc;
            C_SCAUSE:                 rdata_o = r_scause;
            C_STVAL:                  rdata_o = r_stval;
            C_SATP:                   rdata_o = r_satp;
            C_MSTATUS:                rdata_o = r_mstatus;
            C_MISA:                   rdata_o = MISA_VAL;
            C_MEDELEG:                rdata_o = r_medeleg;
            C_MIDELEG:                rdata_o = r_mideleg;
            C_MIE:                    rdata_o = r_mie;
            C_MTVEC:                  rdata_o = r_mtvec;
            C_MSCRATCH:               rdata_o = r_mscratch;
            C_MEPC:                   rdata_o = r_mepc;
            C_MCAUSE:                 rdata_o = r_mcause;
            C_MTVAL:                  rdata_o = r_mtval;
            C_MIP:                    rdata_o = r_mip;
            C_MCYCLE, C_CYCLE:        rdata_o = r_mcycle[31:0];
            C_MCYCLEH, C_CYCLEH:      rdata_o = r_mcycle[63:32];
            C_MINSTRET, C_INSTRET:    rdata_o = r_minstret[31:0];
            C_MINSTRETH, C_INSTRETH:  rdata_o = r_minstret[63:32];
            C_MHARTID:                rdata_o = HART_ID;
            default:                  rillegal_o = 1'b1;
        endcase
        if (w_commit && w_waddr == raddr_i) rdata_o = w_wval;
    end

    assign privilege_o   = r_priv;
    assign csr_mstatus_o = r_mstatus;
    assign csr_mtvec_o   = r_mtvec;
    assign csr_mepc_o    = r_mepc;
    assign csr_mcause_o  = r_mcause;
    assign csr_mtval_o   = r_mtval;
    assign csr_mie_o     = r_mie;
    assign csr_mip_o     = r_mip;
    assign csr_medeleg_o = r_medeleg;
    assign csr_mideleg_o = r_mideleg;
    assign csr_stvec_o   = r_stvec;
    assign csr_sepc_o    = r_sepc;
    assign csr_scause_o  = r_scause;
    assign csr_stval_o   = r_stval;
    assign csr_sstatus_o = r_mstatus & C_SSTATUS_MASK;
    assign csr_sie_o     = r_mie & C_SI_MASK;
    assign csr_sip_o     = r_mip & C_SI_MASK;
    assign csr_satp_o    = r_satp;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_file
// Description : Directed self-checking bench for csr_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_wen_i, inst_wen_i, instret_i, privilege_valid_i;
    logic [11:0] trap_waddr_i, inst_waddr_i, raddr_i;
    logic [31:0] trap_wdata_i, inst_wdata_i;
    logic [1:0]  privilege_i, privilege_o;
    logic [31:0] rdata_o;
    logic        rillegal_o;
    logic [31:0] mstatus, mtvec, mepc, mcause, mtval, mie, mip, medeleg, mideleg;
    logic [31:0] stvec, sepc, scause, stval, sstatus, sie, sip, satp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_file dut (
        .clk(clk), .rst(rst),
        .trap_wen_i(trap_wen_i), .trap_waddr_i(trap_waddr_i), .trap_wdata_i(trap_wdata_i),
        .inst_wen_i(inst_wen_i), .inst_waddr_i(inst_waddr_i), .inst_wdata_i(inst_wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .rillegal_o(rillegal_o),
        .instret_i(instret_i),
        .privilege_valid_i(privilege_valid_i), .privilege_i(privilege_i), .privilege_o(privilege_o),
        .csr_mstatus_o(mstatus), .csr_mtvec_o(mtvec), .csr_mepc_o(mepc), .csr_mcause_o(mcause),
        .csr_mtval_o(mtval), .csr_mie_o(mie), .csr_mip_o(mip), .csr_medeleg_o(medeleg),
        .csr_mideleg_o(mideleg), .csr_stvec_o(stvec), .csr_sepc_o(sepc), .csr_scause_o(scause),
        .csr_stval_o(stval), .csr_sstatus_o(sstatus), .csr_sie_o(sie), .csr_sip_o(sip),
        .csr_satp_o(satp)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic iwrite(input logic [11:0] a, input logic [31:0] d);
        inst_wen_i = 1'b1; inst_waddr_i = a; inst_wdata_i = d;
    endtask

    task automatic idle();
        inst_wen_i = 1'b0; trap_wen_i = 1'b0; privilege_valid_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        raddr_i = a;
        #1;
        check_eq(tag, {32'd0, rdata_o}, {32'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; trap_wen_i = 0; inst_wen_i = 0; instret_i = 0; privilege_valid_i = 0;
        trap_waddr_i = 0; inst_waddr_i = 0; trap_wdata_i = 0; inst_wdata_i = 0;
        raddr_i = 0; privilege_i = 0;

        // Reset
        tick(); tick();
        check_eq("rst_mstatus", {32'd0, mstatus}, 64'h1800);
        check_eq("rst_priv", {62'd0, privilege_o}, 64'd3);
        check_eq("rst_others", {32'd0, mtvec | mepc | mcause | mtval | mie | mip | medeleg |
                 mideleg | stvec | sepc | scause | stval | sstatus | sie | sip | satp}, 64'd0);
        read_chk("rst_mcycleh", 12'hB80, 32'd0);
        read_chk("rst_mcycle", 12'hB00, 32'd0);
        rst = 1'b0;
        tick(); read_chk("mcycle_1", 12'hB00, 32'd1);
        tick(); read_chk("mcycle_2", 12'hB00, 32'd2);

        // Conflict: trap port wins
        trap_wen_i = 1; trap_waddr_i = 12'h341; trap_wdata_i = 32'h8000_0104;
        iwrite(12'h341, 32'h0000_1234);
        tick(); idle();
        check_eq("conflict_mepc", {32'd0, mepc}, 64'h8000_0104);
        iwrite(12'h341, 32'h8000_0003);
        tick(); idle();
        check_eq("mepc_warl", {32'd0, mepc}, 64'h8000_0002);

        // Views
        iwrite(12'h100, 32'hFFFF_FFFF);
        tick(); idle();
        check_eq("sstatus_wr_mstatus", {32'd0, mstatus}, 64'h000C_1922);
        read_chk("sstatus_rd", 12'h100, 32'h000C_0122);
        check_eq("sstatus_o", {32'd0, sstatus}, 64'h000C_0122);
        iwrite(12'h144, 32'hFFFF_FFFF);
        tick(); idle();
        check_eq("sip_wr_mip", {32'd0, mip}, 64'h222);
        // No alias bypass; MPP=2'b10 becomes 2'b00
        iwrite(12'h300, 32'h0000_1000);
        read_chk("no_alias_bypass", 12'h100, 32'h000C_0122);
        tick(); idle();
        check_eq("mpp_warl", {32'd0, mstatus}, 64'h0);

        // Counter carry
        iwrite(12'hB00, 32'hFFFF_FFFE);
        tick(); idle();
        read_chk("mcycle_wr", 12'hB00, 32'hFFFF_FFFE);
        tick(); read_chk("mcycle_ff", 12'hB00, 32'hFFFF_FFFF);
        tick(); read_chk("mcycle_lo0", 12'hB00, 32'h0);
        read_chk("cycleh_1", 12'hC80, 32'h1);
        iwrite(12'hC00, 32'h55);
        read_chk("ro_no_bypass", 12'hC00, 32'h0);
        tick(); idle();
        read_chk("ro_ignored", 12'hC00, 32'h1);
        read_chk("ro_cycleh", 12'hC80, 32'h1);

        // Bypass and illegal
        iwrite(12'h305, 32'h8000_0003);
        read_chk("bypass_mtvec", 12'h305, 32'h8000_0001);
        tick(); idle();
        check_eq("mtvec_warl", {32'd0, mtvec}, 64'h8000_0001);
        read_chk("illegal_rdata", 12'h7C0, 32'h0);
        check_eq("illegal_flag", {63'd0, rillegal_o}, 64'd1);
        raddr_i = 12'h305; #1;
        check_eq("legal_flag", {63'd0, rillegal_o}, 64'd0);
        iwrite(12'h301, 32'h0);
        tick(); idle();
        read_chk("misa_ro", 12'h301, 32'h4014_1101);
        read_chk("mhartid", 12'hF14, 32'h0);

        // Instret
        instret_i = 1;
        tick(); tick(); tick();
        instret_i = 0;
        read_chk("minstret_3", 12'hB02, 32'd3);
        tick();
        read_chk("instret_hold", 12'hC02, 32'd3);

        // Privilege
        privilege_valid_i = 1; privilege_i = 2'd1;
        tick(); idle();
        check_eq("priv_set", {62'd0, privilege_o}, 64'd1);
        privilege_i = 2'd2;
        tick();
        check_eq("priv_hold", {62'd0, privilege_o}, 64'd1);

        // Reset overrides concurrent activity
        rst = 1; trap_wen_i = 1; trap_waddr_i = 12'h341; trap_wdata_i = 32'h100;
        privilege_valid_i = 1; privilege_i = 2'd0; instret_i = 1;
        tick(); idle(); instret_i = 0;
        check_eq("rst_mepc", {32'd0, mepc}, 64'h0);
        check_eq("rst_priv2", {62'd0, privilege_o}, 64'd3);
        check_eq("rst_mstatus2", {32'd0, mstatus}, 64'h1800);
        read_chk("rst_minstret", 12'hB02, 32'd0);
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
